mine_placer: RTL and testbench

Write-side initiator for the Minesweeper board pair. On `start` it places `numMines` distinct mines at pseudo-random coordinates. It drives the mine board's read port to reject occupied cells and the player's protected first cell, then issues one-cycle write strobes. The strobes feed the mine board's `writeEn`/`writeValue` and the adjacency board's `incAdjacent` together. It sits between the game controller (start/done) and the two `Board` instances.

---
 rtl/mine_placer_if.sv | 34 +++
 rtl/mine_placer.sv | 88 ++++++++
 tb/tb_mine_placer.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mine_placer_if.sv
// Bus between the mine placer, the game controller and the mine/adjacency boards.
// master: the placer side; slave: the controller/board side.
interface mine_placer_if #(
    parameter int width  = 8,
    parameter int height = 8
);
    localparam int XW = $clog2(width);
    localparam int YW = $clog2(height);
    localparam int CW = $clog2(width * height + 1);

    logic          start;
    logic [15:0]   seed;
    logic [XW-1:0] safeX;
    logic [YW-1:0] safeY;
    logic [XW-1:0] readX;
    logic [YW-1:0] readY;
    logic          readValue;
    logic [XW-1:0] placeX;
    logic [YW-1:0] placeY;
    logic          placeEn;
    logic          busy;
    logic          done;
    logic [CW-1:0] placedCount;

    modport master (
        input  start, seed, safeX, safeY, readValue,
        output readX, readY, placeX, placeY, placeEn, busy, done, placedCount
    );

    modport slave (
        output start, seed, safeX, safeY, readValue,
        input  readX, readY, placeX, placeY, placeEn, busy, done, placedCount
    );
endinterface

// File: rtl/mine_placer.sv
// Places numMines distinct mines at LFSR-chosen cells, avoiding occupied cells
// and the protected first cell, with one write strobe per mine.
//
// state | meaning
// IDLE  | waiting for start
// GEN   | draw candidate cell from the LFSR
// CHECK | reject out-of-range, protected or already-mined candidate
// PLACE | write strobe to both boards
// DONE  | all mines placed; start re-arms
module mine_placer #(
    parameter int width    = 8,
    parameter int height   = 8,
    parameter int numMines = 10
) (
    input  logic clk,
    input  logic reset,
    mine_placer_if.master bus
);
    localparam int XW = $clog2(width);
    localparam int YW = $clog2(height);
    localparam int CW = $clog2(width * height + 1);
    localparam bit countLegal = (numMines >= 1) && (numMines <= width * height - 1);

    typedef enum logic [2:0] {IDLE, GEN, CHECK, PLACE, DONE} state_t;

    state_t        state;
    logic [15:0]   lfsr;
    logic [15:0]   lfsrNext;
    logic [XW-1:0] candX;
    logic [YW-1:0] candY;
    logic [XW-1:0] safeXq;
    logic [YW-1:0] safeYq;
    logic [CW-1:0] placedCount;
    logic          reject;

    assign lfsrNext = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};

    // readValue is combinational from the candidate, so it is valid during CHECK
    assign reject = (int'(candX) >= width) || (int'(candY) >= height) ||
                    ((candX == safeXq) && (candY == safeYq)) || bus.readValue;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            lfsr        <= 16'hACE1;
            candX       <= '0;
            candY       <= '0;
            safeXq      <= '0;
            safeYq      <= '0;
            placedCount <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (bus.start) begin
                        lfsr        <= (bus.seed == 16'h0000) ? 16'hACE1 : bus.seed;
                        placedCount <= '0;
                        safeXq      <= bus.safeX;
                        safeYq      <= bus.safeY;
                        state       <= countLegal ? GEN : DONE;
                    end
                end
                GEN: begin
                    candX <= lfsr[XW-1:0];
                    candY <= lfsr[XW+YW-1:XW];
                    lfsr  <= lfsrNext;
                    state <= CHECK;
                end
                CHECK: begin
                    state <= reject ? GEN : PLACE;
                end
                PLACE: begin
                    placedCount <= placedCount + 1'b1;
                    state       <= (placedCount + 1'b1 == CW'(numMines)) ? DONE : GEN;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.readX       = candX;
    assign bus.readY       = candY;
    assign bus.placeX      = candX;
    assign bus.placeY      = candY;
    assign bus.placeEn     = (state == PLACE);
    assign bus.busy        = (state == GEN) || (state == CHECK) || (state == PLACE);
    assign bus.done        = (state == DONE);
    assign bus.placedCount = placedCount;
endmodule

// File: tb/tb_mine_placer.sv
// Directed bench for mine_placer: several board geometries, each with a small
// mine-board model answering reads and recording every write strobe.
module tb_mine_placer;
    logic clk_tb = 1'b0;
    logic reset_tb;
    int   checks = 0;
    int   errors = 0;

    always #5 clk_tb = ~clk_tb;

    mine_placer_if #(.width(8), .height(8)) ifA ();
    mine_placer_if #(.width(2), .height(2)) ifB ();
    mine_placer_if #(.width(5), .height(3)) ifC ();
    mine_placer_if #(.width(4), .height(4)) ifD ();
    mine_placer_if #(.width(2), .height(2)) ifE ();

    mine_placer #(.width(8), .height(8), .numMines(10)) dutA (.clk(clk_tb), .reset(reset_tb), .bus(ifA.master));
    mine_placer #(.width(2), .height(2), .numMines(3))  dutB (.clk(clk_tb), .reset(reset_tb), .bus(ifB.master));
    mine_placer #(.width(5), .height(3), .numMines(14)) dutC (.clk(clk_tb), .reset(reset_tb), .bus(ifC.master));
    mine_placer #(.width(4), .height(4), .numMines(0))  dutD (.clk(clk_tb), .reset(reset_tb), .bus(ifD.master));
    mine_placer #(.width(2), .height(2), .numMines(4))  dutE (.clk(clk_tb), .reset(reset_tb), .bus(ifE.master));

    logic memA [64];
    logic memB [4];
    logic memC [32];
    int   pulsesA, dupA, badA;
    int   pulsesB, dupB;
    int   pulsesC, dupC, badC;
    int   pulsesD, pulsesE;
    int   coordsA [$];
    int   seqZero [$];

    assign ifA.readValue = memA[{ifA.readY, ifA.readX}];
    assign ifB.readValue = memB[{ifB.readY, ifB.readX}];
    assign ifC.readValue = memC[{ifC.readY, ifC.readX}];
    assign ifD.readValue = 1'b0;
    assign ifE.readValue = 1'b0;

    always @(posedge clk_tb or posedge reset_tb) begin
        if (reset_tb) begin
            for (int i = 0; i < 64; i++) memA[i] <= 1'b0;
            pulsesA <= 0; dupA <= 0; badA <= 0;
        end else if (ifA.placeEn) begin
            if (memA[{ifA.placeY, ifA.placeX}]) dupA <= dupA + 1;
            if (ifA.placeX == 3'd3 && ifA.placeY == 3'd3) badA <= badA + 1;
            memA[{ifA.placeY, ifA.placeX}] <= 1'b1;
            pulsesA <= pulsesA + 1;
            coordsA.push_back(int'(ifA.placeX) * 16 + int'(ifA.placeY));
        end
    end

    always @(posedge clk_tb or posedge reset_tb) begin
        if (reset_tb) begin
            for (int i = 0; i < 4; i++) memB[i] <= 1'b0;
            pulsesB <= 0; dupB <= 0;
        end else if (ifB.placeEn) begin
            if (memB[{ifB.placeY, ifB.placeX}]) dupB <= dupB + 1;
            memB[{ifB.placeY, ifB.placeX}] <= 1'b1;
            pulsesB <= pulsesB + 1;
        end
    end

    always @(posedge clk_tb or posedge reset_tb) begin
        if (reset_tb) begin
            for (int i = 0; i < 32; i++) memC[i] <= 1'b0;
            pulsesC <= 0; dupC <= 0; badC <= 0;
        end else if (ifC.placeEn) begin
            if (memC[{ifC.placeY, ifC.placeX}]) dupC <= dupC + 1;
            if (ifC.placeX >= 3'd5 || ifC.placeY >= 2'd3 ||
                (ifC.placeX == 3'd4 && ifC.placeY == 2'd2)) badC <= badC + 1;
            memC[{ifC.placeY, ifC.placeX}] <= 1'b1;
            pulsesC <= pulsesC + 1;
        end
    end

    always @(posedge clk_tb or posedge reset_tb) begin
        if (reset_tb) begin
            pulsesD <= 0; pulsesE <= 0;
        end else begin
            if (ifD.placeEn) pulsesD <= pulsesD + 1;
            if (ifE.placeEn) pulsesE <= pulsesE + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic doReset();
        @(negedge clk_tb);
        reset_tb = 1'b1;
        @(negedge clk_tb);
        reset_tb = 1'b0;
        @(negedge clk_tb);
    endtask

    task automatic waitDone(input int which, input string tag);
        int  n = 0;
        logic d = 1'b0;
        do begin
            @(negedge clk_tb);
            n++;
            case (which)
                0:       d = ifA.done;
                1:       d = ifB.done;
                default: d = ifC.done;
            endcase
        end while (!d && n < 5000);
        check(tag, 32'(d), 32'd1);
    endtask

    task automatic runA(input logic [15:0] seedVal);
        coordsA.delete();
        ifA.seed  = seedVal;
        ifA.start = 1'b1;
        @(negedge clk_tb);
        ifA.start = 1'b0;
        waitDone(0, "runA_done");
    endtask

    initial begin
        int n;
        int mined;
        int diffs;
        reset_tb  = 1'b1;
        ifA.start = 1'b0; ifB.start = 1'b0; ifC.start = 1'b0; ifD.start = 1'b0; ifE.start = 1'b0;
        ifA.seed  = 16'h1234; ifA.safeX = 3'd3; ifA.safeY = 3'd3;
        ifB.seed  = 16'hBEEF; ifB.safeX = 1'd0; ifB.safeY = 1'd0;
        ifC.seed  = 16'h0F0F; ifC.safeX = 3'd4; ifC.safeY = 2'd2;
        ifD.seed  = 16'h0001; ifD.safeX = 2'd0; ifD.safeY = 2'd0;
        ifE.seed  = 16'h0001; ifE.safeX = 1'd0; ifE.safeY = 1'd0;
        #2;
        check("rst_busy", 32'(ifA.busy), 32'd0);
        check("rst_done", 32'(ifA.done), 32'd0);
        check("rst_placeEn", 32'(ifA.placeEn), 32'd0);
        check("rst_readX", 32'(ifA.readX), 32'd0);
        check("rst_count", 32'(ifA.placedCount), 32'd0);
        @(negedge clk_tb);
        reset_tb = 1'b0;
        @(negedge clk_tb);

        // Seed 1234: first three candidates (4,6),(1,5),(2,2) are all accepted
        coordsA.delete();
        ifA.seed  = 16'h1234;
        ifA.start = 1'b1;
        @(negedge clk_tb);
        ifA.start = 1'b0;
        check("gen_busy", 32'(ifA.busy), 32'd1);
        check("gen_placeEn", 32'(ifA.placeEn), 32'd0);
        @(negedge clk_tb);
        check("chk_readX", 32'(ifA.readX), 32'd4);
        check("chk_readY", 32'(ifA.readY), 32'd6);
        @(negedge clk_tb);
        check("plc_placeEn", 32'(ifA.placeEn), 32'd1);
        check("plc_placeX", 32'(ifA.placeX), 32'd4);
        check("plc_placeY", 32'(ifA.placeY), 32'd6);
        check("plc_count0", 32'(ifA.placedCount), 32'd0);
        @(negedge clk_tb);
        check("after1_count", 32'(ifA.placedCount), 32'd1);
        check("after1_placeEn", 32'(ifA.placeEn), 32'd0);
        ifA.seed  = 16'h5555;
        ifA.start = 1'b1;
        @(negedge clk_tb);
        ifA.start = 1'b0;
        check("busy_start_busy", 32'(ifA.busy), 32'd1);
        check("busy_start_count", 32'(ifA.placedCount), 32'd1);
        repeat (5) @(negedge clk_tb);
        check("after3_count", 32'(ifA.placedCount), 32'd3);
        check("coord2", 32'(coordsA.size() > 1 ? coordsA[1] : -1), 32'h15);
        check("coord3", 32'(coordsA.size() > 2 ? coordsA[2] : -1), 32'h22);
        waitDone(0, "A_done");
        check("A_pulses", 32'(pulsesA), 32'd10);
        check("A_count", 32'(ifA.placedCount), 32'd10);
        check("A_dup", 32'(dupA), 32'd0);
        check("A_safe", 32'(badA), 32'd0);
        check("A_safe_cell", 32'(memA[27]), 32'd0);
        check("A_busy_end", 32'(ifA.busy), 32'd0);

        // Zero seed must behave exactly like seed ACE1
        doReset();
        runA(16'h0000);
        seqZero = coordsA;
        doReset();
        runA(16'hACE1);
        check("seed_len", 32'(coordsA.size()), 32'd10);
        check("seed0_len", 32'(seqZero.size()), 32'd10);
        diffs = 0;
        for (int i = 0; i < 10; i++)
            if (i >= coordsA.size() || i >= seqZero.size() || coordsA[i] != seqZero[i]) diffs++;
        check("seed_seq_diffs", 32'(diffs), 32'd0);

        // 2x2 with three mines: every cell but the protected one
        ifB.start = 1'b1;
        @(negedge clk_tb);
        ifB.start = 1'b0;
        waitDone(1, "B_done");
        check("B_pulses", 32'(pulsesB), 32'd3);
        check("B_dup", 32'(dupB), 32'd0);
        check("B_cell00", 32'(memB[0]), 32'd0);
        check("B_cell10", 32'(memB[1]), 32'd1);
        check("B_cell01", 32'(memB[2]), 32'd1);
        check("B_cell11", 32'(memB[3]), 32'd1);
        check("B_count", 32'(ifB.placedCount), 32'd3);

        // 5x3 filled except (4,2)
        ifC.start = 1'b1;
        @(negedge clk_tb);
        ifC.start = 1'b0;
        waitDone(2, "C_done");
        check("C_pulses", 32'(pulsesC), 32'd14);
        check("C_bad", 32'(badC), 32'd0);
        check("C_dup", 32'(dupC), 32'd0);
        mined = 0;
        for (int y = 0; y < 3; y++)
            for (int x = 0; x < 5; x++)
                if (memC[y * 8 + x]) mined++;
        check("C_mined", 32'(mined), 32'd14);
        check("C_safe_cell", 32'(memC[2 * 8 + 4]), 32'd0);

        // Illegal mine counts finish at once with nothing placed
        ifD.start = 1'b1;
        ifE.start = 1'b1;
        #1;
        check("D_done_pre", 32'(ifD.done), 32'd0);
        @(negedge clk_tb);
        ifD.start = 1'b0;
        ifE.start = 1'b0;
        check("D_done", 32'(ifD.done), 32'd1);
        check("E_done", 32'(ifE.done), 32'd1);
        check("E_busy", 32'(ifE.busy), 32'd0);
        check("E_count", 32'(ifE.placedCount), 32'd0);
        repeat (3) @(negedge clk_tb);
        check("DE_pulses", 32'(pulsesD + pulsesE), 32'd0);

        // Reset after the fourth strobe clears outputs before the next edge
        doReset();
        ifA.seed  = 16'h1234;
        ifA.start = 1'b1;
        @(negedge clk_tb);
        ifA.start = 1'b0;
        n = 0;
        while (pulsesA < 4 && n < 2000) begin
            @(negedge clk_tb);
            n++;
        end
        check("mid_reached4", 32'(pulsesA), 32'd4);
        check("mid_busy_pre", 32'(ifA.busy), 32'd1);
        reset_tb = 1'b1;
        #1;
        check("mid_busy", 32'(ifA.busy), 32'd0);
        check("mid_done", 32'(ifA.done), 32'd0);
        check("mid_placeEn", 32'(ifA.placeEn), 32'd0);
        check("mid_count", 32'(ifA.placedCount), 32'd0);
        check("mid_readX", 32'(ifA.readX), 32'd0);
        @(negedge clk_tb);
        reset_tb = 1'b0;
        @(negedge clk_tb);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
